// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl -- MEM-stage controller between the EX/MEM pipeline register
// and a word-wide data memory with a req/ack handshake.
//
// Loads and word stores take one bus transaction; byte stores are done as a
// read-modify-write of the containing word. The pipeline is held through
// stall until the access completes. A bus wait longer than TIMEOUT cycles
// aborts the access and sets the sticky err flag.
//
// Ports
//   clk, rst                  clock (rising edge), async active-low reset
//   mem_read, mem_write       access request from EX/MEM (write wins)
//   s_byte, load_byte         byte-store / byte-load qualifiers
//   addr, wdata               byte address and store data
//   stall                     hold IF/ID/EX/EX-MEM registers
//   rdata, rdata_valid        load result (held) and one-cycle completion strobe
//   err                       sticky bus-timeout flag
//   dm_req, dm_we, dm_addr,
//   dm_wdata, dm_rdata, dm_ack  data-memory handshake (word aligned)
module mem_stage_ctrl #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        s_byte,
   input  logic        load_byte,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   output logic        stall,
   output logic [15:0] rdata,
   output logic        rdata_valid,
   output logic        err,
   output logic        dm_req,
   output logic        dm_we,
   output logic [15:0] dm_addr,
   output logic [15:0] dm_wdata,
   input  logic [15:0] dm_rdata,
   input  logic        dm_ack
);

   localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_RD     = 3'd1;
   localparam logic [2:0] S_WR     = 3'd2;
   localparam logic [2:0] S_RMW_RD = 3'd3;
   localparam logic [2:0] S_RMW_WR = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   addr_q, addr_d;
   logic [15:0]   wdata_q, wdata_d;
   logic [15:0]   cap_q, cap_d;
   logic [15:0]   rdata_q, rdata_d;
   logic          lbyte_q, lbyte_d;
   logic          rv_q, rv_d;
   logic          err_q, err_d;

   logic          busy;
   logic          timeout;
   logic [7:0]    ld_byte;
   logic [15:0]   ld_res;
   logic [15:0]   merged;

   always_comb begin
      busy    = (state_q == S_RD) || (state_q == S_WR) ||
                (state_q == S_RMW_RD) || (state_q == S_RMW_WR);
      // The cycle that would take the count to TIMEOUT is the last one allowed.
      timeout = (cnt_q == CW'(TIMEOUT - 1));
      ld_byte = addr_q[0] ? dm_rdata[15:8] : dm_rdata[7:0];
      ld_res  = lbyte_q ? {{8{ld_byte[7]}}, ld_byte} : dm_rdata;
      merged  = addr_q[0] ? {wdata_q[7:0], cap_q[7:0]} : {cap_q[15:8], wdata_q[7:0]};
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      lbyte_d = lbyte_q;
      cap_d   = cap_q;
      rdata_d = rdata_q;
      rv_d    = 1'b0;
      err_d   = err_q;

      // Counter restarts on every state change, otherwise counts unanswered requests.
      if (busy && !dm_ack && !timeout) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = '0;
      end

      case (state_q)
         S_IDLE: begin
            addr_d  = addr;
            wdata_d = wdata;
            lbyte_d = load_byte;
            if (mem_write) begin
               state_d = s_byte ? S_RMW_RD : S_WR;
            end else if (mem_read) begin
               state_d = S_RD;
            end
         end
         S_RD: begin
            if (dm_ack) begin
               state_d = S_DONE;
               rdata_d = ld_res;
               rv_d    = 1'b1;
            end else if (timeout) begin
               state_d = S_DONE;
               rdata_d = '0;
               rv_d    = 1'b1;
               err_d   = 1'b1;
            end
         end
         S_RMW_RD: begin
            if (dm_ack) begin
               state_d = S_RMW_WR;
               cap_d   = dm_rdata;
            end else if (timeout) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end
         end
         S_WR, S_RMW_WR: begin
            if (dm_ack) begin
               state_d = S_DONE;
            end else if (timeout) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         lbyte_q <= 1'b0;
         cap_q   <= '0;
         rdata_q <= '0;
         rv_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         lbyte_q <= lbyte_d;
         cap_q   <= cap_d;
         rdata_q <= rdata_d;
         rv_q    <= rv_d;
         err_q   <= err_d;
      end
   end

   assign stall       = busy | ((state_q == S_IDLE) & (mem_read | mem_write));
   assign dm_req      = busy;
   assign dm_we       = (state_q == S_WR) | (state_q == S_RMW_WR);
   assign dm_addr     = {addr_q[15:1], 1'b0};
   assign dm_wdata    = (state_q == S_RMW_WR) ? merged : wdata_q;
   assign rdata       = rdata_q;
   assign rdata_valid = rv_q;
   assign err         = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

   localparam int TO = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write, s_byte, load_byte;
   logic [15:0] addr, wdata;
   logic        stall, rdata_valid, err;
   logic [15:0] rdata;
   logic        dm_req, dm_we, dm_ack;
   logic [15:0] dm_addr, dm_wdata, dm_rdata;

   always #5 clk = ~clk;

   mem_stage_ctrl #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write), .s_byte(s_byte), .load_byte(load_byte),
      .addr(addr), .wdata(wdata),
      .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .err(err),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ack(dm_ack)
   );

   // Bus phases still owed by the transaction in flight.
   typedef struct packed {
      logic        we;
      logic        merge;
      logic [15:0] addr;
      logic [15:0] data;
   } phase_t;

   phase_t      bus_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] mem [0:31];

   // transaction-level model
   bit          m_done, m_is_load, m_byte, m_a0, m_err;
   logic [15:0] m_wd, m_rdata, m_merge;
   int          m_wait;

   // stimulus / responder control
   bit          adv, rand_mode, inject, dir_mode, no_ack, quiet;
   int          dir_wait, resp_cnt;
   bit          inj_rd, inj_wr, inj_sb, inj_lb;
   logic [15:0] inj_a, inj_wd;

   // per-operation statistics
   int          st_cnt, rv_cnt, req_cnt, rd_cnt, wr_cnt;
   logic [15:0] last_wa, last_wd;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, want %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chkn(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] sext8(input logic [7:0] b);
      return {{8{b[7]}}, b};
   endfunction

   task automatic model_reset();
      bus_q.delete();
      m_done  = 1'b0;
      m_err   = 1'b0;
      m_rdata = '0;
      m_merge = '0;
      m_wait  = 0;
   endtask

   task automatic compare();
      bit          busy_e;
      logic [15:0] wd_e;
      busy_e = (bus_q.size() != 0);
      chk1("stall", stall, busy_e ? 1'b1 : (m_done ? 1'b0 : (mem_read | mem_write)));
      chk1("dm_req", dm_req, busy_e);
      if (busy_e) begin
         chk1("dm_we", dm_we, bus_q[0].we);
         chk("dm_addr", dm_addr, bus_q[0].addr);
         if (bus_q[0].we) begin
            wd_e = bus_q[0].merge ? m_merge : bus_q[0].data;
            chk("dm_wdata", dm_wdata, wd_e);
         end
      end else begin
         chk1("dm_we", dm_we, 1'b0);
      end
      chk("rdata", rdata, m_rdata);
      chk1("rdata_valid", rdata_valid, m_done && m_is_load);
      chk1("err", err, m_err);
   endtask

   task automatic model_step();
      phase_t ph;
      if (bus_q.size() != 0) begin
         if (dm_ack) begin
            ph     = bus_q.pop_front();
            m_wait = 0;
            if (!ph.we) begin
               if (m_is_load)
                  m_rdata = m_byte ? sext8(m_a0 ? dm_rdata[15:8] : dm_rdata[7:0]) : dm_rdata;
               else
                  m_merge = m_a0 ? {m_wd[7:0], dm_rdata[7:0]} : {dm_rdata[15:8], m_wd[7:0]};
            end
            if (bus_q.size() == 0) m_done = 1'b1;
         end else begin
            m_wait++;
            if (m_wait == TO) begin
               m_err  = 1'b1;
               bus_q.delete();
               m_done = 1'b1;
               m_wait = 0;
               if (m_is_load) m_rdata = '0;
            end
         end
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (mem_read || mem_write) begin
         m_is_load = !mem_write;
         m_byte    = mem_write ? s_byte : load_byte;
         m_a0      = addr[0];
         m_wd      = wdata;
         m_wait    = 0;
         ph.addr   = {addr[15:1], 1'b0};
         ph.data   = wdata;
         ph.merge  = 1'b0;
         ph.we     = mem_write && !s_byte;
         bus_q.push_back(ph);
         if (mem_write && s_byte) begin
            ph.we    = 1'b1;
            ph.merge = 1'b1;
            bus_q.push_back(ph);
         end
      end
   endtask

   task automatic apply_op();
      int r;
      if (inject) begin
         mem_read  = inj_rd;
         mem_write = inj_wr;
         s_byte    = inj_sb;
         load_byte = inj_lb;
         addr      = inj_a;
         wdata     = inj_wd;
         inject    = 1'b0;
      end else if (rand_mode) begin
         r         = int'($urandom_range(0, 9));
         addr      = 16'($urandom);
         wdata     = 16'($urandom);
         load_byte = 1'($urandom_range(0, 1));
         s_byte    = (r >= 8) ? 1'b1 : ((r < 6) ? 1'($urandom_range(0, 1)) : 1'b0);
         mem_write = (r >= 6);
         mem_read  = (r >= 3 && r <= 5) ? 1'b1 : ((r >= 6) ? 1'($urandom_range(0, 1)) : 1'b0);
      end else begin
         mem_read  = 1'b0;
         mem_write = 1'b0;
      end
   endtask

   task automatic run_cycle();
      @(posedge clk);
      #1;
      if (adv) apply_op();
      if (dm_req) begin
         if (no_ack)        dm_ack = 1'b0;
         else if (dir_mode) dm_ack = (resp_cnt >= dir_wait);
         else               dm_ack = (resp_cnt >= 5) || ($urandom_range(0, 2) == 0);
         dm_rdata = mem[dm_addr[5:1]];
      end else begin
         dm_ack   = !quiet && ($urandom_range(0, 3) == 0);
         dm_rdata = 16'($urandom);
      end
      @(negedge clk);
      compare();
      if (stall) st_cnt++;
      if (rdata_valid) rv_cnt++;
      if (dm_req) begin
         req_cnt++;
         if (dm_ack) begin
            resp_cnt = 0;
            if (dm_we) begin
               mem[dm_addr[5:1]] = dm_wdata;
               wr_cnt++;
               last_wa = dm_addr;
               last_wd = dm_wdata;
            end else begin
               rd_cnt++;
            end
         end else begin
            resp_cnt++;
         end
      end else begin
         resp_cnt = 0;
      end
      model_step();
      adv = !stall;
   endtask

   task automatic clear_stats();
      st_cnt = 0; rv_cnt = 0; req_cnt = 0; rd_cnt = 0; wr_cnt = 0;
      last_wa = '0; last_wd = '0;
   endtask

   task automatic do_op(input bit rd, input bit wr, input bit sb, input bit lb,
                        input logic [15:0] a, input logic [15:0] wd, input int w);
      bit seen, fin;
      rand_mode = 1'b0;
      dir_mode  = 1'b1;
      dir_wait  = w;
      clear_stats();
      inj_rd = rd; inj_wr = wr; inj_sb = sb; inj_lb = lb; inj_a = a; inj_wd = wd;
      inject = 1'b1;
      seen = 1'b0;
      fin  = 1'b0;
      for (int unsigned i = 0; i < 200; i++) begin
         run_cycle();
         if (stall) seen = 1'b1;
         else if (seen) begin
            fin = 1'b1;
            break;
         end
      end
      if (!fin) begin
         n_vec++;
         n_err++;
         $display("FAIL op_complete: stall never returned low within 200 cycles, addr %h", a);
      end
   endtask

   task automatic drain();
      rand_mode = 1'b0;
      dir_mode  = 1'b0;
      repeat (30) run_cycle();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk1({tag, "_stall"}, stall, 1'b0);
      chk1({tag, "_dm_req"}, dm_req, 1'b0);
      chk1({tag, "_dm_we"}, dm_we, 1'b0);
      chk({tag, "_dm_addr"}, dm_addr, 16'h0000);
      chk({tag, "_dm_wdata"}, dm_wdata, 16'h0000);
      chk({tag, "_rdata"}, rdata, 16'h0000);
      chk1({tag, "_rdata_valid"}, rdata_valid, 1'b0);
      chk1({tag, "_err"}, err, 1'b0);
   endtask

   initial begin
      bit hit;
      rst = 1'b0;
      mem_read = 1'b0; mem_write = 1'b0; s_byte = 1'b0; load_byte = 1'b0;
      addr = '0; wdata = '0; dm_ack = 1'b0; dm_rdata = '0;
      for (int unsigned i = 0; i < 32; i++) mem[i] = 16'($urandom);
      model_reset();
      m_is_load = 1'b0; m_byte = 1'b0; m_a0 = 1'b0; m_wd = '0;
      adv = 1'b1; rand_mode = 1'b0; inject = 1'b0; dir_mode = 1'b0;
      no_ack = 1'b0; quiet = 1'b0; dir_wait = 0; resp_cnt = 0;
      clear_stats();

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b1;

      // random traffic with random wait states and stray acks
      rand_mode = 1'b1;
      repeat (1200) run_cycle();
      drain();

      // word load, two wait cycles
      mem[8] = 16'h1234;
      do_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 2);
      chkn("ld_stall_cycles", st_cnt, 4);
      chk("ld_rdata", rdata, 16'h1234);
      chkn("ld_valid_cycles", rv_cnt, 1);

      // byte loads, zero wait, sign extension on both lanes
      mem[16] = 16'h80FF;
      do_op(1'b1, 1'b0, 1'b0, 1'b1, 16'h0021, 16'h0000, 0);
      chk("lb_hi_rdata", rdata, 16'hFF80);
      chkn("lb_stall_cycles", st_cnt, 2);
      do_op(1'b1, 1'b0, 1'b0, 1'b1, 16'h0020, 16'h0000, 0);
      chk("lb_lo_rdata", rdata, 16'hFFFF);

      // byte store as read-modify-write
      mem[24] = 16'h1234;
      do_op(1'b0, 1'b1, 1'b1, 1'b0, 16'h0031, 16'h00AB, 0);
      chkn("sb_reads", rd_cnt, 1);
      chkn("sb_writes", wr_cnt, 1);
      chk("sb_waddr", last_wa, 16'h0030);
      chk("sb_wdata", last_wd, 16'hAB34);
      chkn("sb_stall_cycles", st_cnt, 3);

      // read+write together is a plain write
      do_op(1'b1, 1'b1, 1'b0, 1'b0, 16'h0041, 16'h5A5A, 1);
      chkn("rw_reads", rd_cnt, 0);
      chkn("rw_writes", wr_cnt, 1);
      chk("rw_waddr", last_wa, 16'h0040);
      chk("rw_wdata", last_wd, 16'h5A5A);
      chk("rw_rdata_kept", rdata, 16'hFFFF);

      // load that is never acknowledged
      no_ack = 1'b1;
      quiet  = 1'b1;
      do_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h0050, 16'h0000, 0);
      chkn("to_req_cycles", req_cnt, 64);
      chkn("to_stall_cycles", st_cnt, 65);
      chk1("to_err", err, 1'b1);
      chk("to_rdata", rdata, 16'h0000);
      chkn("to_valid_cycles", rv_cnt, 1);
      no_ack = 1'b0;
      quiet  = 1'b0;
      dir_mode  = 1'b0;
      rand_mode = 1'b1;
      repeat (200) run_cycle();
      chk1("err_sticky", err, 1'b1);
      drain();

      // reset in the middle of the write half of a byte store
      rand_mode = 1'b0;
      dir_mode  = 1'b1;
      dir_wait  = 3;
      inj_rd = 1'b0; inj_wr = 1'b1; inj_sb = 1'b1; inj_lb = 1'b0;
      inj_a = 16'h0033; inj_wd = 16'h00CD;
      inject = 1'b1;
      hit = 1'b0;
      for (int unsigned i = 0; i < 40; i++) begin
         run_cycle();
         if (dm_req && dm_we) begin
            hit = 1'b1;
            break;
         end
      end
      if (!hit) begin
         n_vec++;
         n_err++;
         $display("FAIL rmw_wr_reach: write phase not seen within 40 cycles");
      end
      #2;
      rst = 1'b0;
      mem_read = 1'b0;
      mem_write = 1'b0;
      dm_ack = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      model_reset();
      resp_cnt = 0;
      adv = 1'b1;
      inject = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      dir_mode = 1'b0;
      clear_stats();
      repeat (5) run_cycle();
      chkn("no_retry_req", req_cnt, 0);

      rand_mode = 1'b1;
      repeat (800) run_cycle();
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
